// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// The master modport is the initiator's view; the slave modport is the requester/fabric side.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_SLAVES)
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    input  req_valid, req_write, req_sel, req_addr, req_wdata, rsp_ready, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_sel, req_addr, req_wdata, rsp_ready, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: turns one valid/ready command at a time into a SETUP/ACCESS transfer
// and returns read data or an error on a registered response channel.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         arst,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_SLAVES-1:0] SEL_LSB  = {{(NUM_SLAVES-1){1'b0}}, 1'b1};
  localparam logic [SEL_WIDTH:0]    SEL_LIM  = (SEL_WIDTH+1)'(NUM_SLAVES);

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_ok_s;
  logic                  timeout_s;

  assign sel_ok_s  = ({1'b0, bus.req_sel} < SEL_LIM);
  // The counter holds the number of ACCESS cycles already spent without pready.
  assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = {CNT_W{1'b0}};
          if (sel_ok_s) begin
            state_d   = SETUP;
            psel_d    = SEL_LSB << bus.req_sel;
            penable_d = 1'b0;
            paddr_d   = bus.req_addr;
            pwrite_d  = bus.req_write;
            pwdata_d  = bus.req_wdata;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d     = RESP;
          psel_d      = {NUM_SLAVES{1'b0}};
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : bus.prdata;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (timeout_s) begin
            state_d     = RESP;
            psel_d      = {NUM_SLAVES{1'b0}};
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ACCESS;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        psel_d      = {NUM_SLAVES{1'b0}};
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus and discards any in-flight command.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      psel_q      <= {NUM_SLAVES{1'b0}};
      penable_q   <= 1'b0;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !arst;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a 4-slave build with a memory responder and a 3-slave build
// for the invalid-select path; responses are checked from a scoreboard queue.
module tb_apb_master;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4)) bus4 ();
  apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(3)) bus3 ();

  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) u_dut4 (
    .clk(clk), .arst(arst), .bus(bus4));
  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) u_dut3 (
    .clk(clk), .arst(arst), .bus(bus3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Memory responder on the 4-slave bus; prdata is inverted while pready is low.
  logic [7:0] mem [4][256];
  int  wcnt;
  int  wait_cfg    = 0;
  bit  never_ready = 1'b0;
  logic [1:0] sidx;

  always_comb begin
    case (bus4.psel)
      4'b0010: sidx = 2'd1;
      4'b0100: sidx = 2'd2;
      4'b1000: sidx = 2'd3;
      default: sidx = 2'd0;
    endcase
  end

  assign bus4.pready = (bus4.psel != 4'b0000) && bus4.penable && !never_ready && (wcnt >= wait_cfg);
  assign bus4.prdata = bus4.pready ? mem[sidx][bus4.paddr] : ~mem[sidx][bus4.paddr];
  assign bus3.pready = 1'b1;
  assign bus3.prdata = 8'h5A;

  always @(posedge clk) begin
    if (arst) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 256; a++) mem[s][a] <= 8'h00;
      mem[2][8'h33] <= 8'hA5;
      wcnt <= 0;
    end else begin
      if (bus4.psel != 4'b0000 && bus4.penable && !bus4.pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (bus4.pready && bus4.pwrite) mem[sidx][bus4.paddr] <= bus4.pwdata;
    end
  end

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic [7:0] id;
  } exp_t;
  exp_t q4[$];
  exp_t q3[$];

  // Scoreboard monitors: every accepted response must match the oldest expectation.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!arst && bus4.rsp_valid && bus4.rsp_ready) begin
      if (q4.size() == 0) begin
        chk("bus4 unexpected response", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk($sformatf("bus4 rsp_rdata id%0d", e.id), bus4.rsp_rdata, e.rdata);
        chk($sformatf("bus4 rsp_err id%0d", e.id), bus4.rsp_err, e.err);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!arst && bus3.rsp_valid && bus3.rsp_ready) begin
      if (q3.size() == 0) begin
        chk("bus3 unexpected response", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        chk($sformatf("bus3 rsp_rdata id%0d", e.id), bus3.rsp_rdata, e.rdata);
        chk($sformatf("bus3 rsp_err id%0d", e.id), bus3.rsp_err, e.err);
      end
    end
  end

  // Must be called away from the rising edge; returns just after the accepting edge.
  task automatic issue4(input bit w, input logic [1:0] sel, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd, input bit exp_err,
                        input bit expect_rsp, input logic [7:0] id);
    bit got = 1'b0;
    bus4.req_write = w;
    bus4.req_sel   = sel;
    bus4.req_addr  = addr;
    bus4.req_wdata = wdata;
    bus4.req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (bus4.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("bus4 accept id%0d", id), {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      if (expect_rsp) q4.push_back({exp_rd, exp_err, id});
      #1;
    end
    bus4.req_valid = 1'b0;
  endtask

  task automatic xfer4(input bit w, input logic [1:0] sel, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rd, input logic [7:0] id);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    issue4(w, sel, addr, wdata, exp_rd, 1'b0, 1'b1, id);
    @(negedge clk);
    chk($sformatf("setup psel id%0d", id), bus4.psel, oh);
    chk($sformatf("setup penable id%0d", id), bus4.penable, 32'd0);
    chk($sformatf("setup paddr id%0d", id), bus4.paddr, addr);
    chk($sformatf("setup pwrite id%0d", id), bus4.pwrite, w);
    if (w) chk($sformatf("setup pwdata id%0d", id), bus4.pwdata, wdata);
    @(negedge clk);
    chk($sformatf("access psel id%0d", id), bus4.psel, oh);
    chk($sformatf("access penable id%0d", id), bus4.penable, 32'd1);
    chk($sformatf("access rsp_valid id%0d", id), bus4.rsp_valid, 32'd0);
    if (w) chk($sformatf("access pwdata id%0d", id), bus4.pwdata, wdata);
    @(negedge clk);
    chk($sformatf("resp rsp_valid id%0d", id), bus4.rsp_valid, 32'd1);
    chk($sformatf("resp psel id%0d", id), bus4.psel, 32'd0);
    chk($sformatf("resp penable id%0d", id), bus4.penable, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pen_n, sel_n;
    bit stable;
    arst = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_write = 1'b0; bus4.req_sel = 2'd0;
    bus4.req_addr = 8'h00; bus4.req_wdata = 8'h00; bus4.rsp_ready = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_sel = 2'd0;
    bus3.req_addr = 8'h00; bus3.req_wdata = 8'h00; bus3.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset psel", bus4.psel, 32'd0);
    chk("reset penable", bus4.penable, 32'd0);
    chk("reset rsp_valid", bus4.rsp_valid, 32'd0);
    chk("reset rsp_rdata", bus4.rsp_rdata, 32'd0);
    chk("reset rsp_err", bus4.rsp_err, 32'd0);
    chk("reset paddr", bus4.paddr, 32'd0);
    chk("reset req_ready", bus4.req_ready, 32'd0);
    arst = 1'b0;
    @(negedge clk);
    chk("idle req_ready", bus4.req_ready, 32'd1);

    // Zero-wait writes and read-back across two slaves.
    xfer4(1'b1, 2'd0, 8'h00, 8'hF0, 8'h00, 8'd1);
    xfer4(1'b1, 2'd1, 8'h00, 8'hE2, 8'h00, 8'd2);
    xfer4(1'b0, 2'd0, 8'h00, 8'h00, 8'hF0, 8'd3);
    xfer4(1'b0, 2'd1, 8'h00, 8'h00, 8'hE2, 8'd4);

    // Three wait states: data must be taken only in the pready cycle.
    wait_cfg = 3;
    issue4(1'b0, 2'd2, 8'h33, 8'h00, 8'hA5, 1'b0, 1'b1, 8'd5);
    pen_n = 0; stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus4.rsp_valid) break;
      if (bus4.penable) pen_n++;
      if (bus4.psel != 4'b0100 || bus4.paddr !== 8'h33) stable = 1'b0;
    end
    chk("wait penable cycles", pen_n, 32'd4);
    chk("wait paddr/psel stable", {31'd0, stable}, 32'd1);
    chk("wait rsp_valid reached", bus4.rsp_valid, 32'd1);
    wait_cfg = 0;

    // pready never comes: abort after 16 ACCESS cycles with an error.
    never_ready = 1'b1;
    issue4(1'b0, 2'd3, 8'h10, 8'h00, 8'h00, 1'b1, 1'b1, 8'd6);
    pen_n = 0; sel_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus4.rsp_valid) break;
      if (bus4.penable) pen_n++;
      if (bus4.psel != 4'b0000) sel_n++;
    end
    chk("timeout penable cycles", pen_n, 32'd16);
    chk("timeout psel cycles", sel_n, 32'd17);
    chk("timeout rsp_valid reached", bus4.rsp_valid, 32'd1);
    never_ready = 1'b0;

    // Reset mid-ACCESS discards the command; no response may follow.
    wait_cfg = 10;
    @(negedge clk);
    issue4(1'b0, 2'd2, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset penable", bus4.penable, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("async reset psel", bus4.psel, 32'd0);
    chk("async reset penable", bus4.penable, 32'd0);
    chk("async reset req_ready", bus4.req_ready, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post-reset rsp_valid", bus4.rsp_valid, 32'd0);
    wait_cfg = 0;
    xfer4(1'b1, 2'd2, 8'h44, 8'h3C, 8'h00, 8'd7);
    xfer4(1'b0, 2'd2, 8'h44, 8'h00, 8'h3C, 8'd8);

    // 3-slave build: select 3 is invalid and stalls on rsp_ready.
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    bus3.req_write = 1'b0; bus3.req_sel = 2'd3; bus3.req_addr = 8'h21; bus3.req_valid = 1'b1;
    chk("bus3 idle req_ready", bus3.req_ready, 32'd1);
    @(posedge clk);
    q3.push_back({8'h00, 1'b1, 8'd9});
    #1;
    bus3.req_sel = 2'd2; bus3.req_addr = 8'h22;
    @(negedge clk);
    chk("bus3 bad sel rsp_valid", bus3.rsp_valid, 32'd1);
    chk("bus3 bad sel rsp_err", bus3.rsp_err, 32'd1);
    chk("bus3 bad sel rsp_rdata", bus3.rsp_rdata, 32'd0);
    chk("bus3 bad sel psel", bus3.psel, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_err !== 1'b1 || bus3.rsp_rdata !== 8'h00 ||
          bus3.req_ready !== 1'b0 || bus3.psel !== 3'b000) stable = 1'b0;
    end
    chk("bus3 stall stable", {31'd0, stable}, 32'd1);
    @(posedge clk);
    #1 bus3.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bus3 back to idle", bus3.req_ready, 32'd1);
    @(posedge clk);
    q3.push_back({8'h5A, 1'b0, 8'd10});
    #1 bus3.req_valid = 1'b0;
    @(negedge clk);
    chk("bus3 held req setup psel", bus3.psel, 32'h4);
    chk("bus3 held req setup penable", bus3.penable, 32'd0);
    @(negedge clk);
    chk("bus3 held req access penable", bus3.penable, 32'd1);
    @(negedge clk);
    chk("bus3 held req rsp_valid", bus3.rsp_valid, 32'd1);

    repeat (3) @(negedge clk);
    chk("bus4 responses outstanding", q4.size(), 32'd0);
    chk("bus3 responses outstanding", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
